if_fetch_queue: RTL
===================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC/address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries (power of 2, >=2).
REQ-003 SHALL have parameter CNT_W, default 32, performance counter width.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  ID not accepting.
- redirect_valid  in  1  branch/mispredict redirect.
- redirect_pc  in  ADDR_W  redirect target.
- imem_req_valid  out  1  fetch request.
- imem_req_addr  out  ADDR_W  request address.
- imem_req_ready  in  1  memory accepts.
- imem_rsp_valid  in  1  in-order response.
- imem_rsp_data  in  ADDR_W  instruction.
- instr_valid  out  1  head entry valid.
- instr  out  ADDR_W  head instruction.
- pc  out  ADDR_W  head PC.
- pc_plus4  out  ADDR_W  pc + 4.
- fetch_state  out  2  FSM state.
- occupancy  out  $clog2(DEPTH)+1  queued entries.
- fetch_cycles, stall_cycles, redirect_count, discard_count  out  CNT_W  counters.

Function
REQ-006 SHALL implement FSM IDLE=00, FETCH=01, FULL=10, DRAIN=11.
REQ-007 IDLE: entered on reset; no request; next cycle -> FETCH.
REQ-008 FETCH: imem_req_valid=1 when occupancy+outstanding < DEPTH and no redirect this cycle; -> FULL when that sum reaches DEPTH.
REQ-009 FULL: imem_req_valid=0; -> FETCH once sum < DEPTH.
REQ-010 Request accepted when imem_req_valid && imem_req_ready; fetch address then advances by 4, wrapping modulo 2^ADDR_W; imem_req_addr SHALL hold stable while unaccepted.
REQ-011 Responses SHALL push {rsp_pc, imem_rsp_data}; rsp_pc starts at RESET_PC and advances by 4 per accepted response.
REQ-012 Credit rule: occupancy+outstanding <= DEPTH always; a response SHALL never be dropped for lack of space.
REQ-013 Head pops when instr_valid && !stall; push and pop in one cycle leave occupancy unchanged.
REQ-014 Output registered queue head; instr_valid=0 when empty or in DRAIN; pc_plus4 = pc+4 wrapping.
REQ-015 redirect_valid (highest priority after reset): same-edge clear of queue; fetch address and rsp_pc <= redirect_pc; no request that cycle; discard counter <= outstanding minus (imem_rsp_valid?1:0); -> DRAIN if result >0 else FETCH.
REQ-016 Response arriving in redirect cycle SHALL be discarded.
REQ-017 DRAIN: no requests; each response discarded, decrements discard counter; -> FETCH when it reaches 0; redirect in DRAIN reapplies REQ-015.
REQ-018 First request after redirect SHALL be at redirect_pc, no earlier than cycle after redirect.
REQ-019 Counters wrap: fetch_cycles +1 per pop; stall_cycles +1 per stall cycle; redirect_count +1 per redirect; discard_count +1 per discarded response.

Reset
REQ-020 Reset SHALL asynchronously force: state IDLE, queue empty, outstanding=0, discard=0, fetch address/rsp_pc=RESET_PC, all counters 0, instr_valid=0, imem_req_valid=0, instr=0, pc=0; pc_plus4=4 (derived).
REQ-021 Reset mid-transaction: in-flight responses after deassert are memory's responsibility to squash; block SHALL not track them.

Structure
REQ-022 Shared package SHALL hold fetch_state_t enum and entry struct {pc, instr}.
REQ-023 Storage SHALL be a sub-module fetch_fifo (DEPTH, width 2*ADDR_W, synchronous clear, push/pop/count); FSM, credit and counters in if_fetch_queue.

Verification
REQ-024 Reset, ready=1, 1-cycle response latency, stall=0 -> requests 0x0,0x4,0x8...; instr_valid from cycle 3; pc sequence 0,4,8.
REQ-025 stall=1 for 10 cycles, DEPTH=4 -> occupancy 4, FULL state, imem_req_valid=0, stall_cycles=10, no response lost.
REQ-026 Redirect to 0x100 with 3 outstanding, 1 arriving same cycle -> queue empty next cycle, DRAIN discards 2, discard_count=3, first request 0x100.
REQ-027 imem_req_ready=0 for 5 cycles -> imem_req_addr stable, outstanding unchanged.
REQ-028 Redirect to 0xFFFFFFFC -> pc 0xFFFFFFFC then 0x0; pc_plus4 wraps to 0x0.
REQ-029 Assert reset mid-DRAIN -> all outputs/counters at REQ-020 values immediately.

Source files
------------

// File: rtl/if_fetch_queue_pkg.sv
// Shared types for the instruction-fetch queue: FSM state encoding and queue entry layout.
package if_fetch_queue_pkg;

    localparam int FQ_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        FULL  = 2'b10,
        DRAIN = 2'b11
    } fetch_state_t;

    typedef struct packed {
        logic [FQ_ADDR_W-1:0] pc;
        logic [FQ_ADDR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// Power-of-two circular buffer holding {pc, instr} entries, with synchronous clear.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // A push is taken when a slot is free or the same-cycle pop frees one
    always_comb begin
        do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
        do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; stale contents are never visible because the head is qualified by count
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: credit-limited request FSM, in-order response queue,
// redirect/drain handling and performance counters.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                CNT_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     imem_req_valid,
    output logic [ADDR_W-1:0]        imem_req_addr,
    input  logic                     imem_req_ready,
    input  logic                     imem_rsp_valid,
    input  logic [ADDR_W-1:0]        imem_rsp_data,
    output logic                     instr_valid,
    output logic [ADDR_W-1:0]        instr,
    output logic [ADDR_W-1:0]        pc,
    output logic [ADDR_W-1:0]        pc_plus4,
    output logic [1:0]               fetch_state,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         fetch_cycles,
    output logic [CNT_W-1:0]         stall_cycles,
    output logic [CNT_W-1:0]         redirect_count,
    output logic [CNT_W-1:0]         discard_count
);

    localparam int                OCC_W     = $clog2(DEPTH) + 1;
    localparam int                SUM_W     = OCC_W + 1;
    localparam logic [SUM_W-1:0]  DEPTH_SUM = SUM_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(3'd4);

    fetch_state_t        state_r;
    fetch_state_t        state_next_s;
    logic [ADDR_W-1:0]   fetch_addr_r;
    logic [ADDR_W-1:0]   rsp_pc_r;
    logic [OCC_W-1:0]    outstanding_r;
    logic [OCC_W-1:0]    discard_r;
    logic [CNT_W-1:0]    fetch_cycles_r;
    logic [CNT_W-1:0]    stall_cycles_r;
    logic [CNT_W-1:0]    redirect_count_r;
    logic [CNT_W-1:0]    discard_count_r;

    logic                req_valid_s;
    logic                req_fire_s;
    logic                rsp_live_s;
    logic                rsp_push_s;
    logic                rsp_discard_s;
    logic                head_valid_s;
    logic                pop_s;
    logic [OCC_W-1:0]    out_next_s;
    logic [OCC_W-1:0]    occ_next_s;
    logic [OCC_W-1:0]    discard_next_s;
    logic [SUM_W-1:0]    sum_now_s;
    logic [SUM_W-1:0]    sum_next_s;
    logic [OCC_W-1:0]    fifo_count_s;
    logic [2*ADDR_W-1:0] fifo_head_s;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (rsp_push_s),
        .push_data ({rsp_pc_r, imem_rsp_data}),
        .pop       (pop_s),
        .head_data (fifo_head_s),
        .count     (fifo_count_s)
    );

    // Credit check, response routing and next-state decode; the FULL/FETCH choice looks at next-cycle credit
    always_comb begin
        state_next_s   = state_r;
        req_valid_s    = 1'b0;
        rsp_push_s     = 1'b0;
        rsp_discard_s  = 1'b0;
        discard_next_s = discard_r;
        head_valid_s   = (fifo_count_s != {OCC_W{1'b0}}) && (state_r != DRAIN);
        pop_s          = head_valid_s && !stall;
        rsp_live_s     = imem_rsp_valid && (outstanding_r != {OCC_W{1'b0}});
        sum_now_s      = SUM_W'(fifo_count_s) + SUM_W'(outstanding_r);

        if (redirect_valid) begin
            rsp_discard_s = rsp_live_s;
        end else begin
            case (state_r)
                FETCH: begin
                    req_valid_s = (sum_now_s < DEPTH_SUM);
                    rsp_push_s  = rsp_live_s;
                end
                FULL:    rsp_push_s    = rsp_live_s;
                DRAIN:   rsp_discard_s = rsp_live_s;
                default: rsp_push_s    = 1'b0;
            endcase
        end

        req_fire_s = req_valid_s && imem_req_ready;
        out_next_s = outstanding_r + OCC_W'(req_fire_s) - OCC_W'(rsp_live_s);
        if (redirect_valid) begin
            occ_next_s = {OCC_W{1'b0}};
        end else begin
            occ_next_s = fifo_count_s + OCC_W'(rsp_push_s) - OCC_W'(pop_s);
        end
        sum_next_s = SUM_W'(occ_next_s) + SUM_W'(out_next_s);

        if (redirect_valid) begin
            discard_next_s = out_next_s;
            state_next_s   = (out_next_s != {OCC_W{1'b0}}) ? DRAIN : FETCH;
        end else begin
            case (state_r)
                IDLE:  state_next_s = FETCH;
                FETCH: state_next_s = (sum_next_s >= DEPTH_SUM) ? FULL : FETCH;
                FULL:  state_next_s = (sum_next_s < DEPTH_SUM) ? FETCH : FULL;
                DRAIN: begin
                    if (rsp_discard_s && (discard_r != {OCC_W{1'b0}})) begin
                        discard_next_s = discard_r - OCC_W'(1'b1);
                    end else begin
                        discard_next_s = discard_r;
                    end
                    state_next_s = (discard_next_s == {OCC_W{1'b0}}) ? FETCH : DRAIN;
                end
                default: state_next_s = IDLE;
            endcase
        end
    end

    // FSM, credit, address tracking and wrapping performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r          <= IDLE;
            fetch_addr_r     <= RESET_PC;
            rsp_pc_r         <= RESET_PC;
            outstanding_r    <= {OCC_W{1'b0}};
            discard_r        <= {OCC_W{1'b0}};
            fetch_cycles_r   <= {CNT_W{1'b0}};
            stall_cycles_r   <= {CNT_W{1'b0}};
            redirect_count_r <= {CNT_W{1'b0}};
            discard_count_r  <= {CNT_W{1'b0}};
        end else begin
            state_r       <= state_next_s;
            outstanding_r <= out_next_s;
            discard_r     <= discard_next_s;
            if (redirect_valid) begin
                fetch_addr_r <= redirect_pc;
                rsp_pc_r     <= redirect_pc;
            end else begin
                if (req_fire_s) begin
                    fetch_addr_r <= fetch_addr_r + PC_STEP;
                end
                if (rsp_push_s) begin
                    rsp_pc_r <= rsp_pc_r + PC_STEP;
                end
            end
            if (pop_s) begin
                fetch_cycles_r <= fetch_cycles_r + CNT_W'(1'b1);
            end
            if (stall) begin
                stall_cycles_r <= stall_cycles_r + CNT_W'(1'b1);
            end
            if (redirect_valid) begin
                redirect_count_r <= redirect_count_r + CNT_W'(1'b1);
            end
            if (rsp_discard_s) begin
                discard_count_r <= discard_count_r + CNT_W'(1'b1);
            end
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = fetch_addr_r;
    assign instr_valid    = head_valid_s;
    assign instr          = head_valid_s ? fifo_head_s[ADDR_W-1:0] : {ADDR_W{1'b0}};
    assign pc             = head_valid_s ? fifo_head_s[2*ADDR_W-1:ADDR_W] : {ADDR_W{1'b0}};
    assign pc_plus4       = pc + PC_STEP;
    assign fetch_state    = state_r;
    assign occupancy      = fifo_count_s;
    assign fetch_cycles   = fetch_cycles_r;
    assign stall_cycles   = stall_cycles_r;
    assign redirect_count = redirect_count_r;
    assign discard_count  = discard_count_r;

endmodule
